// File: rtl/pkg_tpu.sv
// Shared TPU pipeline types: write-back token, data word and source count.
package pkg_tpu;

    localparam int WB_NUM_SRC = 4;

    typedef logic [31:0] data_t;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
    } pipe_exe_tmp_t;

endpackage

// File: rtl/wb_arbiter_v_fifo.sv
// Single-source write-back FIFO (token + data) used by wb_arbiter_v.
// A push into a full FIFO is accepted only when the same cycle also pops.
module wb_fifo
    import pkg_tpu::*;
#(
    parameter int  DEPTH = 4,
    parameter type TYPE  = pipe_exe_tmp_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  TYPE                      push_token,
    input  data_t                    push_data,
    input  logic                     pop,
    output TYPE                      head_token,
    output data_t                    head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    TYPE          mem_token [DEPTH];
    data_t        mem_data  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign head_token = mem_token[rd_ptr];
    assign head_data  = mem_data[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            mem_token[wr_ptr] <= push_token;
            mem_data[wr_ptr]  <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter_v.sv
// Round-robin write-back arbiter: four source FIFOs feed one registered output.
// Optional WB_ARB_PERF_CNT_EN adds O_Conflict_Cnt (cycles with >=2 busy sources).
module wb_arbiter_v
    import pkg_tpu::*;
#(
    parameter int  DEPTH = 4,
    parameter type TYPE  = pipe_exe_tmp_t
) (
    input  logic        clock,
    input  logic        reset,
    input  TYPE         I_Token [WB_NUM_SRC],
    input  data_t       I_Data  [WB_NUM_SRC],
    input  logic        I_WB_Ready,
    output TYPE         O_WB_Token,
    output data_t       O_WB_Data,
    output logic [1:0]  O_WB_Src,
    output logic        O_Stall,
    output logic        O_Overflow
`ifdef WB_ARB_PERF_CNT_EN
    ,
    output logic [15:0] O_Conflict_Cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

    TYPE                   head_token [WB_NUM_SRC];
    data_t                 head_data  [WB_NUM_SRC];
    logic [CW-1:0]         fifo_count [WB_NUM_SRC];
    logic [WB_NUM_SRC-1:0] full;
    logic [WB_NUM_SRC-1:0] empty;
    logic [WB_NUM_SRC-1:0] pop;
    logic [WB_NUM_SRC-1:0] drop;
    logic [1:0]            rr_ptr;
    logic [1:0]            winner;
    logic                  grant_valid;
    logic                  load_en;
    logic                  do_load;

    for (genvar g = 0; g < WB_NUM_SRC; g++) begin : g_fifo
        wb_fifo #(
            .DEPTH (DEPTH),
            .TYPE  (TYPE)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .push       (I_Token[g].v),
            .push_token (I_Token[g]),
            .push_data  (I_Data[g]),
            .pop        (pop[g]),
            .head_token (head_token[g]),
            .head_data  (head_data[g]),
            .count      (fifo_count[g]),
            .full       (full[g]),
            .empty      (empty[g])
        );
    end

    // First non-empty FIFO at or after rr_ptr wins when the output can be (re)loaded.
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
        for (int k = 0; k < WB_NUM_SRC; k++) begin
            if (!grant_valid && !empty[rr_ptr + 2'(k)]) begin
                grant_valid = 1'b1;
                winner      = rr_ptr + 2'(k);
            end
        end
    end

    assign load_en = !O_WB_Token.v || I_WB_Ready;
    assign do_load = load_en && grant_valid;

    always_comb begin
        pop     = '0;
        drop    = '0;
        O_Stall = 1'b0;
        for (int i = 0; i < WB_NUM_SRC; i++) begin
            pop[i]  = do_load && (winner == 2'(i));
            drop[i] = I_Token[i].v && full[i] && !pop[i];
            if (fifo_count[i] >= STALL_LVL) O_Stall = 1'b1;
        end
    end

    // Output register only drops valid when consumed with nothing queued behind it.
    always_ff @(posedge clock) begin
        if (reset) begin
            O_WB_Token <= '0;
            O_WB_Data  <= '0;
            O_WB_Src   <= '0;
            rr_ptr     <= '0;
            O_Overflow <= 1'b0;
        end else begin
            if (do_load) begin
                O_WB_Token <= head_token[winner];
                O_WB_Data  <= head_data[winner];
                O_WB_Src   <= winner;
                rr_ptr     <= winner + 2'd1;
            end else if (load_en) begin
                O_WB_Token.v <= 1'b0;
            end
            if (|drop) O_Overflow <= 1'b1;
        end
    end

`ifdef WB_ARB_PERF_CNT_EN
    logic [2:0] busy_cnt;

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < WB_NUM_SRC; i++) begin
            busy_cnt = busy_cnt + {2'b00, !empty[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            O_Conflict_Cnt <= '0;
        end else if (busy_cnt >= 3'd2 && O_Conflict_Cnt != 16'hFFFF) begin
            O_Conflict_Cnt <= O_Conflict_Cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter_v.sv
// Scoreboard bench for wb_arbiter_v: stimulus queues expected write-backs in
// hand-computed grant order; a negedge monitor checks every consumed output.
module tb_wb_arbiter_v;
    import pkg_tpu::*;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  dst;
        logic [31:0] data;
    } exp_item_t;

    logic          clock = 1'b0;
    logic          reset;
    pipe_exe_tmp_t tok [WB_NUM_SRC];
    data_t         dat [WB_NUM_SRC];
    logic          ready;
    pipe_exe_tmp_t wb_token;
    data_t         wb_data;
    logic [1:0]    wb_src;
    logic          stall;
    logic          overflow;
`ifdef WB_ARB_PERF_CNT_EN
    logic [15:0]   conflict_cnt;
`endif

    int        checks = 0;
    int        errors = 0;
    exp_item_t exp_q [$];

    always #5 clock = ~clock;

    wb_arbiter_v dut (
        .clock      (clock),
        .reset      (reset),
        .I_Token    (tok),
        .I_Data     (dat),
        .I_WB_Ready (ready),
        .O_WB_Token (wb_token),
        .O_WB_Data  (wb_data),
        .O_WB_Src   (wb_src),
        .O_Stall    (stall),
        .O_Overflow (overflow)
`ifdef WB_ARB_PERF_CNT_EN
        ,
        .O_Conflict_Cnt (conflict_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expectOut(input logic [1:0] src, input logic [4:0] dst, input logic [31:0] data);
        exp_item_t e;
        e.src  = src;
        e.dst  = dst;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Drive one push cycle on every source in mask, then return just after that edge.
    task automatic applyStimulus(input logic [3:0] mask, input logic [4:0] dst, input logic [31:0] data);
        for (int i = 0; i < WB_NUM_SRC; i++) begin
            tok[i].v   = mask[i];
            tok[i].dst = dst;
            dat[i]     = data;
        end
        tick(1);
        for (int i = 0; i < WB_NUM_SRC; i++) tok[i].v = 1'b0;
    endtask

    task automatic doReset(input bit expect_drained);
        if (expect_drained) checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < WB_NUM_SRC; i++) tok[i].v = 1'b0;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every output accepted by the register file must match the queue head.
    initial begin
        exp_item_t e;
        forever begin
            @(negedge clock);
            if (!reset && wb_token.v && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: actual src=%0d data=%0h required=none at %0t",
                             wb_src, wb_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_src", 32'(wb_src), 32'(e.src));
                    checkOutput("sb_dst", 32'(wb_token.dst), 32'(e.dst));
                    checkOutput("sb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < WB_NUM_SRC; i++) begin
            tok[i] = '0;
            dat[i] = '0;
        end
        tick(2);
        reset = 1'b0;

        checkOutput("rst_valid", 32'(wb_token.v), 32'd0);
        checkOutput("rst_data", wb_data, 32'd0);
        checkOutput("rst_src", 32'(wb_src), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
`ifdef WB_ARB_PERF_CNT_EN
        checkOutput("rst_conflict", 32'(conflict_cnt), 32'd0);
`endif

        // Lone Math token: visible one cycle after the push edge, for exactly one cycle.
        expectOut(2'd2, 5'd5, 32'h3F80_0000);
        applyStimulus(4'b0100, 5'd5, 32'h3F80_0000);
        checkOutput("lat_not_early", 32'(wb_token.v), 32'd0);
        tick(1);
        checkOutput("lat_valid", 32'(wb_token.v), 32'd1);
        checkOutput("lat_src", 32'(wb_src), 32'd2);
        checkOutput("lat_data", wb_data, 32'h3F80_0000);
        tick(1);
        checkOutput("lat_one_cycle", 32'(wb_token.v), 32'd0);
        checkOutput("idle_data_hold", wb_data, 32'h3F80_0000);

        // All four sources at once after reset: sources 0..3 on consecutive cycles.
        doReset(1'b1);
        for (int n = 0; n < 4; n++) expectOut(2'(n), 5'd4, 32'h4444_0000);
        applyStimulus(4'b1111, 5'd4, 32'h4444_0000);
        for (int n = 0; n < 4; n++) begin
            tick(1);
            checkOutput("all4_valid", 32'(wb_token.v), 32'd1);
            checkOutput("all4_src", 32'(wb_src), 32'(n));
        end
        tick(2);

        // Two entries each on sources 0 and 2: round-robin interleaves them.
        expectOut(2'd0, 5'd1, 32'h1111_0000);
        expectOut(2'd2, 5'd1, 32'h1111_0000);
        expectOut(2'd0, 5'd2, 32'h2222_0000);
        expectOut(2'd2, 5'd2, 32'h2222_0000);
        applyStimulus(4'b0101, 5'd1, 32'h1111_0000);
        applyStimulus(4'b0101, 5'd2, 32'h2222_0000);
        tick(5);

        // Back-pressure: rr_ptr is 3, so Mv wins and holds for 5 cycles of ready low.
        ready = 1'b0;
        expectOut(2'd3, 5'd6, 32'hC0C0_0001);
        expectOut(2'd1, 5'd6, 32'hC0C0_0001);
        expectOut(2'd3, 5'd7, 32'hD0D0_0002);
        applyStimulus(4'b1010, 5'd6, 32'hC0C0_0001);
        applyStimulus(4'b1000, 5'd7, 32'hD0D0_0002);
        for (int n = 0; n < 5; n++) begin
            checkOutput("hold_valid", 32'(wb_token.v), 32'd1);
            checkOutput("hold_src", 32'(wb_src), 32'd3);
            checkOutput("hold_data", wb_data, 32'hC0C0_0001);
            tick(1);
        end
        ready = 1'b1;
        tick(1);
        checkOutput("resume_src", 32'(wb_src), 32'd1);
        tick(3);

        // Fill LdSt1 behind an occupied output: stall from count 3, fifth push dropped.
        doReset(1'b1);
        ready = 1'b0;
        expectOut(2'd3, 5'd3, 32'h3333_0000);
        applyStimulus(4'b1000, 5'd3, 32'h3333_0000);
        tick(1);
        for (int n = 0; n < 4; n++) begin
            expectOut(2'd0, 5'(n), 32'hF000_0000 + 32'(n));
            applyStimulus(4'b0001, 5'(n), 32'hF000_0000 + 32'(n));
            checkOutput("fill_stall", 32'(stall), 32'(n >= 2));
        end
        checkOutput("full_no_ovf", 32'(overflow), 32'd0);
        applyStimulus(4'b0001, 5'd31, 32'hBAD0_0000);
        checkOutput("drop_ovf", 32'(overflow), 32'd1);
        ready = 1'b1;
        tick(7);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        checkOutput("drained_valid", 32'(wb_token.v), 32'd0);
        doReset(1'b1);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO pushed on the same edge it pops: entry kept, no overflow.
        ready = 1'b0;
        expectOut(2'd3, 5'd3, 32'h6666_0000);
        applyStimulus(4'b1000, 5'd3, 32'h6666_0000);
        tick(1);
        for (int n = 0; n < 5; n++) expectOut(2'd0, 5'(n + 8), 32'h7700_0000 + 32'(n));
        for (int n = 0; n < 4; n++) applyStimulus(4'b0001, 5'(n + 8), 32'h7700_0000 + 32'(n));
        ready = 1'b1;
        applyStimulus(4'b0001, 5'd12, 32'h7700_0004);
        ready = 1'b0;
        checkOutput("pp_no_ovf", 32'(overflow), 32'd0);
        checkOutput("pp_stall", 32'(stall), 32'd1);
        checkOutput("pp_src", 32'(wb_src), 32'd0);
        checkOutput("pp_data", wb_data, 32'h7700_0000);
        tick(1);
        ready = 1'b1;
        tick(7);
        checkOutput("pp_ovf_final", 32'(overflow), 32'd0);

        // Two sources pending for three edges, then reset mid-stream.
        doReset(1'b1);
        ready = 1'b0;
        expectOut(2'd3, 5'd3, 32'h9999_0000);
        applyStimulus(4'b1000, 5'd3, 32'h9999_0000);
        tick(1);
        applyStimulus(4'b0011, 5'd10, 32'hAAAA_0000);
`ifdef WB_ARB_PERF_CNT_EN
        checkOutput("conflict_start", 32'(conflict_cnt), 32'd0);
`endif
        tick(3);
`ifdef WB_ARB_PERF_CNT_EN
        checkOutput("conflict_cnt", 32'(conflict_cnt), 32'd3);
`endif
        checkOutput("pre_rst_valid", 32'(wb_token.v), 32'd1);
        reset = 1'b1;
        tok[2].v   = 1'b1;
        tok[2].dst = 5'd9;
        dat[2]     = 32'hDEAD_0000;
        tick(1);
        checkOutput("midrst_valid", 32'(wb_token.v), 32'd0);
        checkOutput("midrst_ovf", 32'(overflow), 32'd0);
        checkOutput("midrst_stall", 32'(stall), 32'd0);
`ifdef WB_ARB_PERF_CNT_EN
        checkOutput("midrst_conflict", 32'(conflict_cnt), 32'd0);
`endif
        tick(1);
        tok[2].v = 1'b0;
        reset    = 1'b0;
        exp_q.delete();
        ready    = 1'b1;
        tick(3);
        checkOutput("post_rst_valid", 32'(wb_token.v), 32'd0);
        checkOutput("sb_final_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
